// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR generator and its checker.
// The polynomial lives here only, so generator and checker cannot drift apart.
package lfsr_pkg;

   localparam int LFSR_WIDTH = 4;

   // Checker synchronisation states
   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   // Next LFSR word: shift left, feed back XOR of the two top bits
   function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
      return {s[LFSR_WIDTH-2:0], s[LFSR_WIDTH-1] ^ s[LFSR_WIDTH-2]};
   endfunction

endpackage

// File: rtl/lfsr_checker_step.sv
// Combinational predictor: next LFSR word from the current reference word.
module lfsr_checker_step
   import lfsr_pkg::*;
#(
   parameter int WIDTH = LFSR_WIDTH
) (
   input  logic [WIDTH-1:0] cur_i,
   output logic [WIDTH-1:0] next_o
);

   // The package function covers the standard width; other widths use the
   // same tap rule written out for the requested width.
   if (WIDTH == LFSR_WIDTH) begin : g_pkg
      assign next_o = lfsr_next(cur_i);
   end else begin : g_generic
      assign next_o = {cur_i[WIDTH-2:0], cur_i[WIDTH-1] ^ cur_i[WIDTH-2]};
   end

endmodule

// File: rtl/lfsr_checker.sv
// LFSR stream checker: hunts for a nonzero word, confirms LOCK_CNT correct
// predictions, then flywheels through errors until LOSS_CNT misses in a row.
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int WIDTH    = LFSR_WIDTH,
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int CNT_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             clr_i,
   output logic             locked_o,
   output logic             err_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic             err_sat_o
);

   localparam int CW = $clog2(LOCK_CNT + 1);
   localparam int MW = $clog2(LOSS_CNT + 1);
   localparam logic [CW-1:0] LOCK_V = CW'(LOCK_CNT);
   localparam logic [MW-1:0] LOSS_V = MW'(LOSS_CNT);

   state_e           state_q;
   logic [WIDTH-1:0] ref_q;
   logic [CW-1:0]    cnt_q;
   logic [MW-1:0]    miss_q;
   logic             locked_q;
   logic             err_q;
   logic [CNT_W-1:0] err_count_q;
   logic [CNT_W-1:0] err_count_d;
   logic             err_sat_q;
   logic             err_sat_d;

   logic [WIDTH-1:0] next_ref_s;
   logic             match_s;
   logic             zero_s;
   logic             miss_event_s;
   logic [CW-1:0]    cnt_inc_s;
   logic [MW-1:0]    miss_inc_s;
   logic [CNT_W-1:0] count_inc_s;

   lfsr_checker_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .cur_i  (ref_q),
      .next_o (next_ref_s)
   );

   assign match_s      = (data_i == next_ref_s);
   assign zero_s       = (data_i == {WIDTH{1'b0}});
   assign miss_event_s = valid_i && (state_q == ST_LOCKED) && !match_s;
   assign cnt_inc_s    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
   assign miss_inc_s   = miss_q + {{(MW-1){1'b0}}, 1'b1};
   assign count_inc_s  = err_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

   // Error counter next value: clear wins, otherwise saturating increment
   always_comb begin
      err_count_d = err_count_q;
      err_sat_d   = err_sat_q;
      if (clr_i) begin
         err_count_d = {CNT_W{1'b0}};
         err_sat_d   = 1'b0;
      end else if (miss_event_s && !(&err_count_q)) begin
         err_count_d = count_inc_s;
         err_sat_d   = err_sat_q | (&count_inc_s);
      end else begin
         err_count_d = err_count_q;
         err_sat_d   = err_sat_q;
      end
   end

   // Synchronisation FSM with registered lock/error outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_HUNT;
         ref_q       <= {WIDTH{1'b0}};
         cnt_q       <= {CW{1'b0}};
         miss_q      <= {MW{1'b0}};
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         err_count_q <= {CNT_W{1'b0}};
         err_sat_q   <= 1'b0;
      end else begin
         err_q       <= miss_event_s;
         err_count_q <= err_count_d;
         err_sat_q   <= err_sat_d;
         if (valid_i) begin
            case (state_q)
               ST_HUNT: begin
                  if (!zero_s) begin
                     ref_q   <= data_i;
                     cnt_q   <= {CW{1'b0}};
                     state_q <= ST_SYNC;
                  end
               end
               ST_SYNC: begin
                  if (match_s) begin
                     ref_q <= data_i;
                     cnt_q <= cnt_inc_s;
                     if (cnt_inc_s == LOCK_V) begin
                        state_q  <= ST_LOCKED;
                        miss_q   <= {MW{1'b0}};
                        locked_q <= 1'b1;
                     end
                  end else if (!zero_s) begin
                     ref_q <= data_i;
                     cnt_q <= {CW{1'b0}};
                  end else begin
                     state_q <= ST_HUNT;
                  end
               end
               ST_LOCKED: begin
                  if (match_s) begin
                     ref_q  <= data_i;
                     miss_q <= {MW{1'b0}};
                  end else begin
                     // Flywheel: keep predicting so isolated bit errors do not resync
                     ref_q  <= next_ref_s;
                     miss_q <= miss_inc_s;
                     if (miss_inc_s == LOSS_V) begin
                        state_q  <= ST_HUNT;
                        locked_q <= 1'b0;
                     end
                  end
               end
               default: begin
                  state_q  <= ST_HUNT;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign locked_o    = locked_q;
   assign err_o       = err_q;
   assign err_count_o = err_count_q;
   assign err_sat_o   = err_sat_q;

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Downstream consumer of the 4-bit LFSR generator: samples the generator's parallel state word each valid cycle and predicts the next word from the previous one. Reports lock, per-sample error pulses and a saturating error count. Used as the self-checking sink in LFSR/PRBS link tests and as the on-chip monitor behind the generator.

## Interface
- `WIDTH`, 4: LFSR word width; must match the generator.
- `LOCK_CNT`, 4: consecutive correct predictions required to declare lock (≥1).
- `LOSS_CNT`, 3: consecutive mispredictions while locked that drop lock (≥1).
- `CNT_W`, 16: width of the error counter.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset; deasserted synchronously to `clk` by the system.
- `valid`  in  1  `data` is a new LFSR word this cycle.
- `data`  in  WIDTH  LFSR output word (`op` of the generator).
- `clr`  in  1  synchronous clear of `err_count` and `err_sat`; lock state untouched.
- `locked`  out  1  checker is in LOCKED.
- `err`  out  1  one-cycle pulse per mispredicted sample while LOCKED.
- `err_count`  out  CNT_W  errors since reset/clear, saturating.
- `err_sat`  out  1  sticky; set when `err_count` reaches all-ones.

## Operation
- Prediction rule (must equal the generator): `next(s) = {s[WIDTH-2:0], s[WIDTH-1] ^ s[WIDTH-2]}`; period 15 for WIDTH=4; all-zero is illegal.
- Internal registers: `ref` (last accepted word), `cnt` (match counter), `miss` (consecutive-miss counter), state.
- HUNT: on `valid` with nonzero `data`: `ref<=data`, `cnt<=0`, go SYNC. Zero `data` ignored.
- SYNC: on `valid`: if `data==next(ref)`: `ref<=data`, `cnt<=cnt+1`; when incremented `cnt` equals `LOCK_CNT` go LOCKED, `miss<=0`. Else if `data!=0`: `ref<=data`, `cnt<=0` (restart). Else (zero): go HUNT. No `err` in HUNT/SYNC.
- LOCKED: on `valid`: match → `ref<=data`, `miss<=0`. Mismatch (including zero) → `err` pulse, `err_count` increment (saturating), `ref<=next(ref)` (flywheel; single bit errors do not resync), `miss<=miss+1`; when incremented `miss` equals `LOSS_CNT` go HUNT.
- Cycles without `valid` change nothing.
- `clr` and an error in the same cycle: clear wins; `err` still pulses; count reads 0.
- `err_count` holds at all-ones; `err_sat` set same edge count becomes all-ones, cleared only by `clr`/reset.

## Timing
- Reset (async assert): state HUNT, `ref=0`, `cnt=0`, `miss=0`; outputs `locked=0`, `err=0`, `err_count=0`, `err_sat=0`.
- All outputs registered; one-cycle latency: sample at edge N → `err`/`err_count`/`locked` update visible after edge N.
- `locked` rises on the edge accepting the `LOCK_CNT`-th consecutive correct sample; falls on the edge accepting the `LOSS_CNT`-th consecutive miss.
- Reset mid-run: immediate return to reset values; relock needs `LOCK_CNT+1` valid samples after release.
- No backpressure; `valid` may be high every cycle.

## Structure
- Package `lfsr_pkg`: `WIDTH` default, state enum (HUNT, SYNC, LOCKED), function `lfsr_next()` shared with the generator so polynomial is defined once.
- Sub-module `lfsr_step`: combinational `next(ref)` predictor, instantiated once; rest is a single FSM module.

## Test plan
- Reset, then feed 0001,0010,0100,1001,0011 (valid every cycle) → `locked` rises after the 5th sample edge, `err` never pulses.
- While locked, replace 0110 with 0111, continue 1101,1010 → one `err` pulse, `err_count=1`, `locked` stays 1, next samples match via flywheel.
- While locked, feed three garbage words (1111,1111,1111) → three `err` pulses, `err_count`+3, `locked` falls on third; correct stream relocks after 5 samples.
- Feed 0000 in HUNT and SYNC → no state advance, no `err`; 0000 while locked → `err` pulse.
- Force `err_count` to 0xFFFE via CNT_W=2 build (count 2), inject 2 errors → count sticks at 3, `err_sat=1`; `clr` → 0 and 0.
- Assert `rst` low mid-stream, asynchronous to `clk` → outputs zero before next edge; release → relock after 5 valid samples; gaps in `valid` do not break lock.
